airi5c_uart_rx: RTL and testbench
=================================

Name: airi5c_uart_rx

Overview:
UART receive path, the downstream peer of the UART transmitter in the airi5c UART peripheral. It synchronises the serial rx line and detects and validates the start bit. It samples data, parity and stop bits at mid-bit using the shared ctrl_reg frame format, then buffers received words in an internal airi5c_uart_fifo for the bus interface to pop. It drives active-low rts hardware flow control toward the remote transmitter and reports sticky frame, parity and overflow errors.

Parameters:
STACK_ADDR_WIDTH, 5, FIFO address width; depth = 2^STACK_ADDR_WIDTH words
RTS_MARGIN, 2, free-entry margin; rts deasserts when size >= 2^STACK_ADDR_WIDTH - RTS_MARGIN

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous, active-low reset
clear  in  1  sync: flush FIFO, abort frame, clear error flags
rx  in  1  serial input, asynchronous, idle high
rts  out  1  request-to-send, active low (0 = ready to receive)
ctrl_reg  in  32  [31:29] data_bits (bits = value+5), [28:27] parity, [26:25] stop_bits, [24] flow_ctrl, [23:0] baud_reg (clk cycles per bit)
err_clr  in  1  sync: clear all error flags
pop  in  1  read strobe, FIFO read port
data_out  out  9  FIFO head word, LSB-aligned, unused upper bits 0
size  out  STACK_ADDR_WIDTH+1  FIFO fill level
empty  out  1  FIFO empty
full  out  1  FIFO full
frame_error  out  1  sticky: stop bit sampled 0
parity_error  out  1  sticky: parity mismatch
overflow_error  out  1  sticky: word received while FIFO full

Behaviour:
- Reset: rts=1, all error flags 0, state IDLE, counter 0, bit_idx 0, shift data 0, push 0, FIFO empty (size 0, empty 1, full 0). rx synchroniser flops reset to 1.
- rx passes a 2-FF synchroniser (rx_stable); 2-cycle latency. All decisions use rx_stable only.
- FSM is one-hot: IDLE, START, DATA, PARITY, STOP; illegal encoding -> IDLE.
- IDLE: counter<=1, bit_idx<=0, data<=0. If rx_stable==0 -> START.
- START: when counter == (baud_reg>>1)-1: rx_stable==0 -> counter<=0, DATA; rx_stable==1 -> IDLE (glitch rejected, nothing pushed). Otherwise counter++.
- DATA: when counter == baud_reg-1: data[bit_idx]<=rx_stable (LSB first), counter<=0. If bit_idx == data_bits+4 -> PARITY if parity != `UART_PARITY_NONE, else STOP. Otherwise bit_idx++. Otherwise counter++.
- PARITY: sample at counter == baud_reg-1.
  - Even: required bit = ^data.
  - Odd: required bit = ~^data.
  - Mismatch sets a per-frame parity flag. Then counter<=0, STOP.
- STOP: sample at counter == baud_reg-1, i.e. mid first stop bit.
  - Sample 0 -> frame_error<=1.
  - Push one cycle: data word goes to FIFO even if a parity/frame error occurred; parity_error<=1 if the frame flag is set.
  - Return to IDLE immediately. Extra stop bits (1.5/2) are not checked, so back-to-back frames resynchronise.
- Push while full: word dropped, FIFO unchanged, overflow_error<=1. A pop and push in the same cycle are handled by the FIFO; push when full and pop in the same cycle is accepted.
- Error flags: sticky until err_clr or clear. A set and a clear in the same cycle: set wins.
- clear: FIFO flushed, FSM -> IDLE, counters 0, error flags 0. If rx_stable is still low after clear, a new START begins. Mid-frame clear discards the partial word.
- rts (registered): flow_ctrl == `UART_FLOW_CTRL_OFF -> 0. Otherwise 1 when size >= 2^STACK_ADDR_WIDTH - RTS_MARGIN, else 0. Updates one cycle after size changes.
- Counter is 25 bits; comparisons zero-extend baud_reg. baud_reg < 2 is unsupported.
- ctrl_reg changes mid-frame are undefined; software changes it only while idle with the FIFO empty.

Test Plan:
- baud_reg=16, 8N1 (data_bits=3, parity NONE, stop 1), send 0xA5 -> after stop-bit sample empty=0, size=1, data_out=0x0A5, no error flags; pop -> empty=1.
- 8E1, send 0x3C with parity bit 1 (correct is 0) -> data_out=0x03C, parity_error=1. err_clr pulse -> 0. Send 0x3C with parity 0 -> parity_error stays 0.
- 8N1, send 0x55 with stop bit driven 0 -> word 0x055 pushed, frame_error=1. Next frame 0x12 is received correctly.
- Glitch: rx low for 4 cycles with baud_reg=16 -> FSM returns to IDLE, size stays 0, no flags.
- STACK_ADDR_WIDTH=2, RTS_MARGIN=1, flow_ctrl ON: send 5 frames 0x01..0x05 without popping. Expect rts=1 once size=3, full=1 at size 4, fifth word dropped, overflow_error=1. Pops return 0x01..0x04. clear -> size 0, rts 0, flags 0.
- 9 data bits (data_bits=4), odd parity, 2 stop bits: send 0x1FF then immediately 0x100 -> both received in order, parity_error=0, frame_error=0.

Source files
------------

// File: rtl/airi5c_uart_rx.sv
// airi5c UART receiver: rx synchroniser, mid-bit sampling FSM,
// receive FIFO, rts flow control and sticky error flags.
module airi5c_uart_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   size,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (size == '0);
  assign full     = size[ADDR_WIDTH];
  assign do_pop   = pop && !empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push  = push && (!full || pop);
  assign data_out = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      size   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      size   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      size <= size + {{ADDR_WIDTH{1'b0}}, do_push}
                   - {{ADDR_WIDTH{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr] <= data_in;
  end
endmodule

module airi5c_uart_rx #(
  parameter int STACK_ADDR_WIDTH = 5,
  parameter int RTS_MARGIN       = 2
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      clear,
  input  logic                      rx,
  output logic                      rts,
  input  logic [31:0]               ctrl_reg,
  input  logic                      err_clr,
  input  logic                      pop,
  output logic [8:0]                data_out,
  output logic [STACK_ADDR_WIDTH:0] size,
  output logic                      empty,
  output logic                      full,
  output logic                      frame_error,
  output logic                      parity_error,
  output logic                      overflow_error
);
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic       FLOW_OFF    = 1'b0;
  localparam logic [STACK_ADDR_WIDTH:0] RTS_LEVEL =
    (STACK_ADDR_WIDTH+1)'((1 << STACK_ADDR_WIDTH) - RTS_MARGIN);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;

  logic [2:0]  data_bits;
  logic [1:0]  parity;
  logic        flow_ctrl;
  logic [23:0] baud_reg;

  assign data_bits = ctrl_reg[31:29];
  assign parity    = ctrl_reg[28:27];
  assign flow_ctrl = ctrl_reg[24];
  assign baud_reg  = ctrl_reg[23:0];

  state_t      state;
  logic        rx_meta;
  logic        rx_stable;
  logic [24:0] counter;
  logic [3:0]  bit_idx;
  logic [8:0]  data;
  logic        push;
  logic        par_flag;

  logic [24:0] bit_last;
  logic [24:0] half_last;
  logic [3:0]  idx_last;
  logic        bit_hit;
  logic        half_hit;
  logic        par_req;
  logic        stop_hit;
  logic        fe_set;
  logic        pe_set;
  logic        ovf_set;
  logic        flag_clr;

  assign bit_last  = {1'b0, baud_reg} - 25'd1;
  assign half_last = {2'b00, baud_reg[23:1]} - 25'd1;
  assign idx_last  = {1'b0, data_bits} + 4'd4;
  assign bit_hit   = (counter == bit_last);
  assign half_hit  = (counter == half_last);
  assign par_req   = (parity == PARITY_EVEN) ? ^data : ~^data;

  assign stop_hit = (state == STOP) && bit_hit && !clear;
  assign fe_set   = stop_hit && !rx_stable;
  assign pe_set   = stop_hit && par_flag;
  assign ovf_set  = push && full && !pop && !clear;
  assign flag_clr = clear || err_clr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_meta   <= 1'b1;
      rx_stable <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_stable <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      counter  <= '0;
      bit_idx  <= '0;
      data     <= '0;
      push     <= 1'b0;
      par_flag <= 1'b0;
    end else begin
      push <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        counter  <= '0;
        bit_idx  <= '0;
        data     <= '0;
        par_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter  <= 25'd1;
            bit_idx  <= '0;
            data     <= '0;
            par_flag <= 1'b0;
            if (!rx_stable)
              state <= START;
          end
          START: begin
            if (half_hit) begin
              counter <= '0;
              state   <= rx_stable ? IDLE : DATA;
            end else begin
              counter <= counter + 25'd1;
            end
          end
          DATA: begin
            if (bit_hit) begin
              data[bit_idx] <= rx_stable;
              counter       <= '0;
              if (bit_idx == idx_last)
                state <= (parity != PARITY_NONE) ? PARITY : STOP;
              else
                bit_idx <= bit_idx + 4'd1;
            end else begin
              counter <= counter + 25'd1;
            end
          end
          PARITY: begin
            if (bit_hit) begin
              par_flag <= (rx_stable != par_req);
              counter  <= '0;
              state    <= STOP;
            end else begin
              counter <= counter + 25'd1;
            end
          end
          STOP: begin
            // only the first stop bit is checked so back-to-back frames resync
            if (bit_hit) begin
              push    <= 1'b1;
              counter <= '0;
              state   <= IDLE;
            end else begin
              counter <= counter + 25'd1;
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      frame_error    <= 1'b0;
      parity_error   <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      if (flag_clr) begin
        frame_error    <= 1'b0;
        parity_error   <= 1'b0;
        overflow_error <= 1'b0;
      end
      if (fe_set)
        frame_error <= 1'b1;
      if (pe_set)
        parity_error <= 1'b1;
      if (ovf_set)
        overflow_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      rts <= 1'b1;
    else
      rts <= (flow_ctrl != FLOW_OFF) && (size >= RTS_LEVEL);
  end

  airi5c_uart_fifo #(
    .ADDR_WIDTH (STACK_ADDR_WIDTH),
    .DATA_WIDTH (9)
  ) fifo (
    .clk      (clk),
    .n_reset  (n_reset),
    .clear    (clear),
    .push     (push),
    .data_in  (data),
    .pop      (pop),
    .data_out (data_out),
    .size     (size),
    .empty    (empty),
    .full     (full)
  );
endmodule

// File: tb/tb_airi5c_uart_rx.sv
// Directed and random frames for airi5c_uart_rx, checked against
// a queue-based model of the received word stream and error flags.
module tb_airi5c_uart_rx;
  localparam int AW     = 2;
  localparam int MARGIN = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          clear = 1'b0;
  logic          rx = 1'b1;
  logic          rts;
  logic [31:0]   ctrl_reg = '0;
  logic          err_clr = 1'b0;
  logic          pop = 1'b0;
  logic [8:0]    data_out;
  logic [AW:0]   size;
  logic          empty;
  logic          full;
  logic          frame_error;
  logic          parity_error;
  logic          overflow_error;

  int n_chk  = 0;
  int n_fail = 0;
  int baud   = 16;
  bit flow   = 1'b0;
  logic [8:0] q [$];
  bit exp_pe  = 1'b0;
  bit exp_fe  = 1'b0;
  bit exp_ovf = 1'b0;

  airi5c_uart_rx #(.STACK_ADDR_WIDTH(AW), .RTS_MARGIN(MARGIN)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .clear          (clear),
    .rx             (rx),
    .rts            (rts),
    .ctrl_reg       (ctrl_reg),
    .err_clr        (err_clr),
    .pop            (pop),
    .data_out       (data_out),
    .size           (size),
    .empty          (empty),
    .full           (full),
    .frame_error    (frame_error),
    .parity_error   (parity_error),
    .overflow_error (overflow_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int nbits, input int par, input bit fc);
    logic [2:0] db;
    logic [1:0] pp;
    db = 3'(nbits - 5);
    pp = 2'(par);
    flow = fc;
    ctrl_reg = {db, pp, 2'b00, fc, 24'(baud)};
  endtask

  task automatic send_bit(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  // par: 0 none, 1 even, 2 odd
  task automatic send_frame(input logic [8:0] d, input int nbits,
                            input int par, input bit bad_par,
                            input bit bad_stop, input int nstop);
    logic [8:0] w;
    int ones;
    logic pbit;
    w = d & 9'((1 << nbits) - 1);
    ones = $countones(w);
    send_bit(1'b0, baud);
    for (int i = 0; i < nbits; i++)
      send_bit(w[i], baud);
    if (par != 0) begin
      pbit = (par == 1) ? 1'((ones % 2)) : 1'(1 - (ones % 2));
      if (bad_par) pbit = ~pbit;
      send_bit(pbit, baud);
      if (bad_par) exp_pe = 1'b1;
    end
    if (bad_stop) begin
      send_bit(1'b0, baud / 2 + 3);
      send_bit(1'b1, baud);
      exp_fe = 1'b1;
    end else begin
      send_bit(1'b1, baud * nstop);
    end
    if (q.size() == DEPTH) exp_ovf = 1'b1;
    else q.push_back(w);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".size"}, 32'(size), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    if (n > 0) chk({tag, ".data"}, 32'(data_out), 32'(q[0]));
    chk({tag, ".pe"}, 32'(parity_error), 32'(exp_pe));
    chk({tag, ".fe"}, 32'(frame_error), 32'(exp_fe));
    chk({tag, ".ovf"}, 32'(overflow_error), 32'(exp_ovf));
    chk({tag, ".rts"}, 32'(rts),
        32'(flow && (n >= DEPTH - MARGIN)));
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    void'(q.pop_front());
    repeat (2) @(negedge clk);
  endtask

  task automatic do_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_pe = 1'b0;
    exp_fe = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    set_cfg(8, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst.rts", 32'(rts), 32'd1);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.size", 32'(size), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.flags", 32'({frame_error, parity_error, overflow_error}), 32'd0);
    chk("rst.data", 32'(data_out), 32'd0);
    n_reset = 1'b1;
    repeat (4) @(negedge clk);
    check_all("idle");

    // 8N1 basic
    send_frame(9'h0A5, 8, 0, 0, 0, 1);
    repeat (4) @(negedge clk);
    check_all("8n1");
    do_pop();
    check_all("8n1.pop");

    // 8E1 bad then good parity
    set_cfg(8, 1, 1'b0);
    send_frame(9'h03C, 8, 1, 1, 0, 1);
    repeat (4) @(negedge clk);
    check_all("8e1.bad");
    do_pop();
    do_err_clr();
    check_all("8e1.clr");
    send_frame(9'h03C, 8, 1, 0, 0, 1);
    repeat (4) @(negedge clk);
    check_all("8e1.good");
    do_pop();

    // framing error then recovery
    set_cfg(8, 0, 1'b0);
    send_frame(9'h055, 8, 0, 0, 1, 1);
    repeat (4) @(negedge clk);
    check_all("fe");
    do_pop();
    send_frame(9'h012, 8, 0, 0, 0, 1);
    repeat (4) @(negedge clk);
    check_all("fe.next");
    do_pop();
    do_err_clr();

    // start-bit glitch
    send_bit(1'b0, 4);
    send_bit(1'b1, 40);
    check_all("glitch");

    // flow control and overflow
    set_cfg(8, 0, 1'b1);
    repeat (2) @(negedge clk);
    check_all("fc.idle");
    for (int i = 1; i <= 5; i++) begin
      send_frame(9'(i), 8, 0, 0, 0, 1);
      repeat (4) @(negedge clk);
      check_all($sformatf("fc.f%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      do_pop();
      check_all($sformatf("fc.pop%0d", i));
    end
    send_frame(9'h006, 8, 0, 0, 0, 1);
    repeat (4) @(negedge clk);
    check_all("fc.refill");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    q.delete();
    exp_pe = 1'b0;
    exp_fe = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_all("clear");

    // 9O2 back-to-back
    set_cfg(9, 2, 1'b0);
    send_frame(9'h1FF, 9, 2, 0, 0, 2);
    send_frame(9'h100, 9, 2, 0, 0, 2);
    repeat (4) @(negedge clk);
    check_all("9o2.a");
    do_pop();
    check_all("9o2.b");
    do_pop();

    // random frame formats
    for (int i = 0; i < 12; i++) begin
      int nb;
      int pr;
      int ns;
      bit bp;
      bit bs;
      logic [8:0] d;
      nb = $urandom_range(5, 9);
      pr = $urandom_range(0, 2);
      ns = $urandom_range(1, 2);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 5) == 0);
      d = 9'($urandom);
      set_cfg(nb, pr, 1'b0);
      repeat (2) @(negedge clk);
      send_frame(d, nb, pr, bp, bs, ns);
      repeat (4) @(negedge clk);
      check_all($sformatf("rnd%0d", i));
      do_pop();
      do_err_clr();
      check_all($sformatf("rnd%0d.clr", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
